ext_code_sequencer: RTL and testbench

Synchronous playback controller for an 8-entry, 32-bit output-code table. The host loads codes and per-step dwell times, arms a run, and each rising edge of the external trigger plays the next entry for a programmed number of clocks. Entries are played from a host-selected last index down to entry 0. The block drives the 32-channel code bus that feeds the channel outputs.

---
 rtl/ext_code_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ext_code_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_code_sequencer.sv
// Trigger-driven playback of an 8-entry code/dwell table, stepping from a host-chosen
// last index down to entry 0 and holding each code for its programmed dwell.
module ext_code_sequencer #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned CODE_W      = 32,
    parameter int unsigned DWELL_W     = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iWR_FLAG,
    input  logic [IDX_W-1:0]   iWR_ADDR,
    input  logic [CODE_W-1:0]  iWR_CODE,
    input  logic [DWELL_W-1:0] iWR_DWELL,
    input  logic [IDX_W-1:0]   iLAST_INDEX,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic               iTrigger,
    output logic [CODE_W-1:0]  oCode,
    output logic               oCodeValid,
    output logic [IDX_W-1:0]   oIndex,
    output logic               oBusy,
    output logic               oDone,
    output logic               oWrErr
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StArmed = 2'd1;
    localparam logic [1:0] StPlay  = 2'd2;

    localparam logic [DWELL_W-1:0] DwellOne = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               valid_q, valid_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               wr_err_q, wr_err_d;

    logic [CODE_W-1:0]  code_tbl_q  [NUM_ENTRIES];
    logic [DWELL_W-1:0] dwell_tbl_q [NUM_ENTRIES];

    logic trig_meta_q, trig_sync_q, trig_prev_q, trig_edge_q;

    logic               wr_en;
    logic [DWELL_W-1:0] dwell_sel;
    logic [DWELL_W-1:0] dwell_load;

    assign wr_en      = iWR_FLAG && (state_q == StIdle);
    assign dwell_sel  = dwell_tbl_q[idx_q];
    assign dwell_load = (dwell_sel == '0) ? DwellOne : dwell_sel;

    // Two-flop synchronizer, then a registered rising-edge pulse.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            trig_prev_q <= 1'b0;
            trig_edge_q <= 1'b0;
        end else begin
            trig_meta_q <= iTrigger;
            trig_sync_q <= trig_meta_q;
            trig_prev_q <= trig_sync_q;
            trig_edge_q <= trig_sync_q & ~trig_prev_q;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                code_tbl_q[i]  <= '0;
                dwell_tbl_q[i] <= '0;
            end
        end else if (wr_en) begin
            code_tbl_q[iWR_ADDR]  <= iWR_CODE;
            dwell_tbl_q[iWR_ADDR] <= iWR_DWELL;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        code_d   = code_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        wr_err_d = iWR_FLAG && (state_q != StIdle);

        if (iAbort && (state_q != StIdle)) begin
            state_d = StIdle;
            code_d  = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (iStart) begin
                        idx_d   = iLAST_INDEX;
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (trig_edge_q) begin
                        code_d  = code_tbl_q[idx_q];
                        cnt_d   = dwell_load;
                        valid_d = 1'b1;
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (cnt_q == DwellOne) begin
                        code_d  = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        if (idx_q == '0) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            idx_d   = idx_q - 1'b1;
                            state_d = StArmed;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    code_d  = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign oCode      = code_q;
    assign oCodeValid = valid_q;
    assign oIndex     = idx_q;
    assign oBusy      = (state_q != StIdle);
    assign oDone      = done_q;
    assign oWrErr     = wr_err_q;

endmodule

// File: tb/tb_ext_code_sequencer.sv
// Randomized bench for ext_code_sequencer; expectations come from a table model
// that plays entries last..0 with width max(dwell,1) and a three-edge trigger latency.
module tb_ext_code_sequencer;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iWR_FLAG;
    logic [2:0]  iWR_ADDR;
    logic [31:0] iWR_CODE;
    logic [15:0] iWR_DWELL;
    logic [2:0]  iLAST_INDEX;
    logic        iStart;
    logic        iAbort;
    logic        iTrigger;
    logic [31:0] oCode;
    logic        oCodeValid;
    logic [2:0]  oIndex;
    logic        oBusy;
    logic        oDone;
    logic        oWrErr;

    ext_code_sequencer dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iWR_FLAG    (iWR_FLAG),
        .iWR_ADDR    (iWR_ADDR),
        .iWR_CODE    (iWR_CODE),
        .iWR_DWELL   (iWR_DWELL),
        .iLAST_INDEX (iLAST_INDEX),
        .iStart      (iStart),
        .iAbort      (iAbort),
        .iTrigger    (iTrigger),
        .oCode       (oCode),
        .oCodeValid  (oCodeValid),
        .oIndex      (oIndex),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oWrErr      (oWrErr)
    );

    always #5 iClk = ~iClk;

    logic [31:0] ref_code  [8];
    logic [15:0] ref_dwell [8];
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    always @(negedge iClk) if (oDone === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [31:0] c, input logic [15:0] d,
                               input bit accept);
        iWR_FLAG = 1'b1; iWR_ADDR = a; iWR_CODE = c; iWR_DWELL = d;
        tick();
        iWR_FLAG = 1'b0;
        if (accept) begin
            ref_code[a]  = c;
            ref_dwell[a] = d;
        end
    endtask

    // Fires one trigger and measures the resulting step; retrig/abort_at are in-step cycles.
    task automatic play_step(input int retrig, input int abort_at, output int lat,
                             output logic [31:0] code, output logic [2:0] idx,
                             output int width, output logic done);
        iTrigger = 1'b0;
        repeat (3) tick();
        iTrigger = 1'b1;
        lat = 0;
        while (lat <= 20) begin
            tick();
            if (oCodeValid === 1'b1) break;
            lat++;
        end
        code = oCode; idx = oIndex; width = 0; done = 1'b0;
        iTrigger = 1'b0;
        if (oCodeValid !== 1'b1) begin
            lat = -1;
            return;
        end
        width = 1;
        while (width < 70000) begin
            if (abort_at != 0 && width == abort_at) iAbort = 1'b1;
            if (retrig != 0 && width == retrig) iTrigger = 1'b1;
            if (retrig != 0 && width == retrig + 2) iTrigger = 1'b0;
            tick();
            iAbort = 1'b0;
            if (oCodeValid !== 1'b1) break;
            width++;
        end
        done = oDone;
        iTrigger = 1'b0;
    endtask

    task automatic run_sequence(input int last, input string tag);
        int lat, width, exp_w, d0;
        logic [31:0] code;
        logic [2:0] idx;
        logic done;
        d0 = done_cnt;
        iLAST_INDEX = 3'(last); iStart = 1'b1;
        tick();
        iStart = 1'b0;
        n_checks++;
        if (oBusy !== 1'b1 || oIndex !== 3'(last))
            $display("FAIL %s_arm: busy=%b idx=%0d, required busy=1 idx=%0d", tag, oBusy, oIndex,
                     last);
        else n_pass++;
        for (int i = last; i >= 0; i--) begin
            play_step(0, 0, lat, code, idx, width, done);
            exp_w = (ref_dwell[i] == 16'd0) ? 1 : int'(ref_dwell[i]);
            n_checks++;
            if (lat !== 3) $display("FAIL %s_lat[%0d]: got %0d, required 3", tag, i, lat);
            else n_pass++;
            n_checks++;
            if (code !== ref_code[i] || idx !== 3'(i))
                $display("FAIL %s_code[%0d]: got %h@%0d, required %h@%0d", tag, i, code, idx,
                         ref_code[i], i);
            else n_pass++;
            n_checks++;
            if (width !== exp_w)
                $display("FAIL %s_width[%0d]: got %0d, required %0d", tag, i, width, exp_w);
            else n_pass++;
            n_checks++;
            if (done !== (i == 0))
                $display("FAIL %s_done[%0d]: got %b, required %b", tag, i, done, (i == 0));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (oBusy !== 1'b0 || oIndex !== 3'd0 || oCode !== 32'd0 || done_cnt - d0 !== 1)
            $display("FAIL %s_end: busy=%b idx=%0d code=%h dones=%0d, required 0/0/0/1", tag,
                     oBusy, oIndex, oCode, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset();
        int d0;
        iRst = 1'b0;
        repeat (2) tick();
        iRst = 1'b1;
        tick();
        n_checks++;
        if ({oCode, oCodeValid, oIndex, oBusy, oDone, oWrErr} !== '0)
            $display("FAIL reset_outputs: got code=%h v=%b idx=%0d busy=%b done=%b err=%b, required 0",
                     oCode, oCodeValid, oIndex, oBusy, oDone, oWrErr);
        else n_pass++;
        write_entry(3'd3, 32'hDEADBEEF, 16'd5, 1'b1);
        d0 = done_cnt;
        iLAST_INDEX = 3'd3; iStart = 1'b1;
        tick();
        iStart = 1'b0; iTrigger = 1'b1;
        repeat (4) tick();
        iTrigger = 1'b0;
        n_checks++;
        if (oCodeValid !== 1'b1 || oCode !== 32'hDEADBEEF)
            $display("FAIL reset_prerun: got v=%b code=%h, required 1 deadbeef", oCodeValid, oCode);
        else n_pass++;
        iRst = 1'b0;
        tick();
        iRst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ref_code[i] = '0; ref_dwell[i] = '0;
        end
        n_checks++;
        if ({oCode, oCodeValid, oIndex, oBusy, oDone, oWrErr} !== '0)
            $display("FAIL reset_midrun: got code=%h v=%b idx=%0d busy=%b, required 0", oCode,
                     oCodeValid, oIndex, oBusy);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (done_cnt !== d0) $display("FAIL reset_nodone: got %0d, required %0d", done_cnt, d0);
        else n_pass++;
        run_sequence(3, "reset_run");
    endtask

    task automatic test_basic();
        write_entry(3'd2, 32'hA5A5A5A5, 16'd4, 1'b1);
        write_entry(3'd1, 32'h0000FFFF, 16'd1, 1'b1);
        write_entry(3'd0, 32'h80000001, 16'd0, 1'b1);
        run_sequence(2, "basic");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++)
                write_entry(3'(i), $urandom, 16'($urandom_range(0, 5)), 1'b1);
            run_sequence($urandom_range(0, 7), $sformatf("rand%0d", r));
        end
    endtask

    task automatic test_trigger_during_play();
        int lat, width;
        logic [31:0] code;
        logic [2:0] idx;
        logic done;
        write_entry(3'd1, $urandom, 16'd10, 1'b1);
        write_entry(3'd0, $urandom, 16'($urandom_range(1, 4)), 1'b1);
        iLAST_INDEX = 3'd1; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        play_step(5, 0, lat, code, idx, width, done);
        n_checks++;
        if (width !== 10 || code !== ref_code[1])
            $display("FAIL retrig_step1: got width=%0d code=%h, required 10 %h", width, code,
                     ref_code[1]);
        else n_pass++;
        repeat (10) tick();
        n_checks++;
        if (oCodeValid !== 1'b0 || oBusy !== 1'b1 || oIndex !== 3'd0)
            $display("FAIL retrig_armed: got v=%b busy=%b idx=%0d, required 0 1 0", oCodeValid,
                     oBusy, oIndex);
        else n_pass++;
        play_step(0, 0, lat, code, idx, width, done);
        n_checks++;
        if (code !== ref_code[0] || done !== 1'b1 || lat !== 3)
            $display("FAIL retrig_step0: got code=%h done=%b lat=%0d, required %h 1 3", code,
                     done, lat, ref_code[0]);
        else n_pass++;
    endtask

    task automatic test_abort();
        int lat, width, d0;
        logic [31:0] code;
        logic [2:0] idx;
        logic done;
        write_entry(3'd2, $urandom, 16'd6, 1'b1);
        write_entry(3'd1, $urandom, 16'($urandom_range(0, 3)), 1'b1);
        write_entry(3'd0, $urandom, 16'($urandom_range(0, 3)), 1'b1);
        d0 = done_cnt;
        iLAST_INDEX = 3'd2; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        play_step(0, 2, lat, code, idx, width, done);
        n_checks++;
        if (width !== 2 || oCode !== 32'd0 || oBusy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_play: got width=%0d code=%h busy=%b done=%b, required 2 0 0 0",
                     width, oCode, oBusy, done);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (done_cnt !== d0 || oBusy !== 1'b0)
            $display("FAIL abort_nodone: got dones=%0d busy=%b, required %0d 0", done_cnt, oBusy,
                     d0);
        else n_pass++;
        run_sequence(2, "abort_rerun");
    endtask

    task automatic test_write_protect();
        int lat, width;
        logic [31:0] code;
        logic [2:0] idx;
        logic done;
        logic [31:0] new_code;
        iLAST_INDEX = 3'd2; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        write_entry(3'd1, ~ref_code[1], 16'd7, 1'b0);
        n_checks++;
        if (oWrErr !== 1'b1) $display("FAIL wrerr_pulse: got %b, required 1", oWrErr);
        else n_pass++;
        iLAST_INDEX = 3'd5; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        n_checks++;
        if (oWrErr !== 1'b0 || oIndex !== 3'd2 || oBusy !== 1'b1)
            $display("FAIL wrerr_clear_start_busy: got err=%b idx=%0d busy=%b, required 0 2 1",
                     oWrErr, oIndex, oBusy);
        else n_pass++;
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        n_checks++;
        if (oBusy !== 1'b0) $display("FAIL abort_armed: got busy=%b, required 0", oBusy);
        else n_pass++;
        run_sequence(2, "wrprot");
        new_code = $urandom;
        iWR_FLAG = 1'b1; iWR_ADDR = 3'd0; iWR_CODE = new_code; iWR_DWELL = 16'd3;
        iLAST_INDEX = 3'd0; iStart = 1'b1;
        tick();
        iWR_FLAG = 1'b0; iStart = 1'b0;
        ref_code[0] = new_code; ref_dwell[0] = 16'd3;
        n_checks++;
        if (oWrErr !== 1'b0 || oBusy !== 1'b1)
            $display("FAIL wr_start_same: got err=%b busy=%b, required 0 1", oWrErr, oBusy);
        else n_pass++;
        play_step(0, 0, lat, code, idx, width, done);
        n_checks++;
        if (code !== new_code || width !== 3 || done !== 1'b1)
            $display("FAIL wr_start_play: got %h w=%0d done=%b, required %h 3 1", code, width,
                     done, new_code);
        else n_pass++;
    endtask

    // Full-scale dwell on the first step only; the rest stay short.
    task automatic test_boundary();
        for (int i = 0; i < 7; i++) write_entry(3'(i), $urandom, 16'($urandom_range(1, 3)), 1'b1);
        write_entry(3'd7, $urandom, 16'hFFFF, 1'b1);
        run_sequence(7, "boundary");
        repeat (5) tick();
        n_checks++;
        if (oIndex !== 3'd0 || oBusy !== 1'b0)
            $display("FAIL boundary_idle: got idx=%0d busy=%b, required 0 0", oIndex, oBusy);
        else n_pass++;
    endtask

    initial begin
        iRst = 1'b0; iWR_FLAG = 1'b0; iWR_ADDR = '0; iWR_CODE = '0; iWR_DWELL = '0;
        iLAST_INDEX = '0; iStart = 1'b0; iAbort = 1'b0; iTrigger = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ref_code[i] = '0; ref_dwell[i] = '0;
        end
        test_reset();
        test_basic();
        test_random();
        test_trigger_during_play();
        test_abort();
        test_write_protect();
        test_boundary();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
